// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: PC / IF/ID / ID/EX hold, bubble and flush controls for
// load-use hazards, taken branches and multi-cycle MULT/DIV, plus saturating event counters.
module hazard_stall_ctrl #(
    parameter int MD_CYCLES = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_md_start,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_md_cnt;
    logic [3:0]       w_md_cnt_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_hazard;

    // Register 0 is never a real load destination, so it cannot create a hazard.
    assign w_hazard = ex_mem_read && (ex_rt != 5'd0) &&
                      ((id_uses_rs && (id_rs == ex_rt)) ||
                       (id_uses_rt && (id_rt == ex_rt)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= RUN;
            r_md_cnt <= 4'd0;
        end else begin
            r_state  <= w_next_state;
            r_md_cnt <= w_md_cnt_next;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_md_cnt_next = r_md_cnt;
        case (r_state)
            RUN: begin
                if (!branch_taken && ex_md_start) begin
                    w_next_state  = MD_WAIT;
                    w_md_cnt_next = MD_LOAD;
                end
            end
            MD_WAIT: begin
                if (r_md_cnt == 4'd1) begin
                    w_next_state  = RUN;
                    w_md_cnt_next = 4'd0;
                end else begin
                    w_md_cnt_next = r_md_cnt - 4'd1;
                end
            end
            default: begin
                w_next_state  = RUN;
                w_md_cnt_next = 4'd0;
            end
        endcase
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_bubble = 1'b0;
        md_busy     = 1'b0;
        md_done     = 1'b0;
        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (ex_md_start) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_write = 1'b0;
                    end else if (w_hazard) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                MD_WAIT: begin
                    md_busy = 1'b1;
                    if (r_md_cnt == 4'd1) begin
                        md_done = 1'b1;
                    end else begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_write = 1'b0;
                    end
                end
                default: begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_write = 1'b0;
                end
            endcase
        end
    end

    // Counters hold at all-ones instead of wrapping so long runs stay meaningful.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if ((r_state == RUN) && branch_taken && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: expected output vectors are queued as stimulus is
// driven and compared mid-cycle; a second instance with 4-bit counters exercises saturation.
module tb_hazard_stall_ctrl;

    // Output vector order: {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, md_busy, md_done}
    localparam logic [6:0] RUNV = 7'b1101000;
    localparam logic [6:0] LU   = 7'b0001100;
    localparam logic [6:0] BR   = 7'b1111100;
    localparam logic [6:0] MDS  = 7'b0000000;
    localparam logic [6:0] MDW  = 7'b0000010;
    localparam logic [6:0] MDD  = 7'b1101011;
    localparam logic [6:0] RSTV = 7'b0000100;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       mr;
        logic [4:0] ert;
        logic       md;
        logic       br;
        logic [6:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  idRs = '0, idRt = '0, exRt = '0;
    logic        idUsesRs = 1'b0, idUsesRt = 1'b0, exMemRead = 1'b0;
    logic        exMdStart = 1'b0, branchTaken = 1'b0;

    logic        pcWrite, ifidWrite, ifidFlush, idexWrite, idexBubble, mdBusy, mdDone;
    logic [15:0] stallCnt, flushCnt;
    logic        sPc, sIfidW, sIfidF, sIdexW, sIdexB, sBusy, sDone;
    logic [3:0]  sStall, sFlush;

    logic [6:0]  sbq[$];
    logic [6:0]  expV;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MD_CYCLES(4), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .id_rs(idRs), .id_rt(idRt),
        .id_uses_rs(idUsesRs), .id_uses_rt(idUsesRt), .ex_mem_read(exMemRead), .ex_rt(exRt),
        .ex_md_start(exMdStart), .branch_taken(branchTaken),
        .pc_write(pcWrite), .ifid_write(ifidWrite), .ifid_flush(ifidFlush),
        .idex_write(idexWrite), .idex_bubble(idexBubble), .md_busy(mdBusy), .md_done(mdDone),
        .stall_cnt(stallCnt), .flush_cnt(flushCnt)
    );

    hazard_stall_ctrl #(.MD_CYCLES(4), .CNT_W(4)) u_dut_sat (
        .clk(clk), .reset(reset), .id_rs(idRs), .id_rt(idRt),
        .id_uses_rs(idUsesRs), .id_uses_rt(idUsesRt), .ex_mem_read(exMemRead), .ex_rt(exRt),
        .ex_md_start(exMdStart), .branch_taken(branchTaken),
        .pc_write(sPc), .ifid_write(sIfidW), .ifid_flush(sIfidF),
        .idex_write(sIdexW), .idex_bubble(sIdexB), .md_busy(sBusy), .md_done(sDone),
        .stall_cnt(sStall), .flush_cnt(sFlush)
    );

    function automatic logic [6:0] obsVec();
        return {pcWrite, ifidWrite, ifidFlush, idexWrite, idexBubble, mdBusy, mdDone};
    endfunction

    task automatic clearInputs();
        idRs = '0; idRt = '0; idUsesRs = 1'b0; idUsesRt = 1'b0;
        exMemRead = 1'b0; exRt = '0; exMdStart = 1'b0; branchTaken = 1'b0;
    endtask

    // Drive one cycle of stimulus just after the edge, queue its expectation, stop mid-cycle.
    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        idRs = v.rs; idRt = v.rt; idUsesRs = v.urs; idUsesRt = v.urt;
        exMemRead = v.mr; exRt = v.ert; exMdStart = v.md; branchTaken = v.br;
        sbq.push_back(v.exp);
        @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        clearInputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        vec_t v[2];
        v[0] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, RUNV};
        v[1] = '{5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, LU};
        doReset();
        for (int i = 0; i < 2; i++) begin
            step(v[i]);
            expV = sbq.pop_front();
            checks++;
            if (obsVec() !== expV) begin
                errors++;
                $display("[TB] FAIL reset_run[%0d] got %b expected %b", i, obsVec(), expV);
            end
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        sbq.push_back(RSTV);
        #1;
        expV = sbq.pop_front();
        checks++;
        if (obsVec() !== expV) begin
            errors++;
            $display("[TB] FAIL reset_async got %b expected %b", obsVec(), expV);
        end
        checks++;
        if (stallCnt !== 16'd0 || flushCnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_cnts got %0d/%0d expected 0/0", stallCnt, flushCnt);
        end
        @(negedge clk);
        clearInputs();
        reset = 1'b0;
        step(v[0]);
        expV = sbq.pop_front();
        checks++;
        if (obsVec() !== expV || stallCnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_release got %b cnt %0d expected %b cnt 0", obsVec(), stallCnt, expV);
        end
    endtask

    task automatic test_load_use();
        vec_t v[8];
        v[0] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, LU};
        v[1] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, RUNV};
        v[2] = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, RUNV};
        v[3] = '{5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, LU};
        v[4] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, RUNV};
        v[5] = '{5'd1, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, RUNV};
        v[6] = '{5'd9, 5'd2, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, RUNV};
        v[7] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, RUNV};
        doReset();
        for (int i = 0; i < 8; i++) begin
            step(v[i]);
            expV = sbq.pop_front();
            checks++;
            if (obsVec() !== expV) begin
                errors++;
                $display("[TB] FAIL load_use[%0d] got %b expected %b", i, obsVec(), expV);
            end
        end
        checks++;
        if (stallCnt !== 16'd2 || flushCnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL load_use_cnts got %0d/%0d expected 2/0", stallCnt, flushCnt);
        end
    endtask

    task automatic test_mult();
        vec_t v[5];
        v[0] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, MDS};
        v[1] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, MDW};
        v[2] = '{5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, MDW};
        v[3] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, MDD};
        v[4] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, RUNV};
        doReset();
        for (int i = 0; i < 5; i++) begin
            step(v[i]);
            expV = sbq.pop_front();
            checks++;
            if (obsVec() !== expV) begin
                errors++;
                $display("[TB] FAIL mult[%0d] got %b expected %b", i, obsVec(), expV);
            end
        end
        checks++;
        if (stallCnt !== 16'd3 || flushCnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL mult_cnts got %0d/%0d expected 3/0", stallCnt, flushCnt);
        end
    endtask

    task automatic test_branch_hazard();
        vec_t v[2];
        v[0] = '{5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, BR};
        v[1] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, RUNV};
        doReset();
        for (int i = 0; i < 2; i++) begin
            step(v[i]);
            expV = sbq.pop_front();
            checks++;
            if (obsVec() !== expV) begin
                errors++;
                $display("[TB] FAIL branch[%0d] got %b expected %b", i, obsVec(), expV);
            end
        end
        checks++;
        if (stallCnt !== 16'd0 || flushCnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL branch_cnts got %0d/%0d expected 0/1", stallCnt, flushCnt);
        end
    endtask

    task automatic test_reset_md_wait();
        vec_t v[8];
        v[0] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, MDS};
        v[1] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, MDW};
        v[2] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, RUNV};
        v[3] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, RUNV};
        v[4] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, MDS};
        v[5] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, MDW};
        v[6] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, MDW};
        v[7] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, MDD};
        doReset();
        for (int i = 0; i < 2; i++) begin
            step(v[i]);
            expV = sbq.pop_front();
            checks++;
            if (obsVec() !== expV) begin
                errors++;
                $display("[TB] FAIL md_rst_pre[%0d] got %b expected %b", i, obsVec(), expV);
            end
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        sbq.push_back(RSTV);
        #1;
        expV = sbq.pop_front();
        checks++;
        if (obsVec() !== expV) begin
            errors++;
            $display("[TB] FAIL md_rst_async got %b expected %b", obsVec(), expV);
        end
        @(negedge clk);
        clearInputs();
        reset = 1'b0;
        for (int i = 2; i < 8; i++) begin
            step(v[i]);
            expV = sbq.pop_front();
            checks++;
            if (obsVec() !== expV) begin
                errors++;
                $display("[TB] FAIL md_rst_post[%0d] got %b expected %b", i, obsVec(), expV);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[11];
        for (int i = 0; i < 8; i++) begin
            v[i] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0,
                     (i % 4 == 0) ? MDS : ((i % 4 == 3) ? MDD : MDW)};
        end
        v[8]  = '{5'd6, 5'd6, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, LU};
        v[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, RUNV};
        v[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, RUNV};
        doReset();
        for (int i = 0; i < 11; i++) begin
            step(v[i]);
            expV = sbq.pop_front();
            checks++;
            if (obsVec() !== expV) begin
                errors++;
                $display("[TB] FAIL b2b[%0d] got %b expected %b", i, obsVec(), expV);
            end
        end
        checks++;
        if (stallCnt !== 16'd7) begin
            errors++;
            $display("[TB] FAIL b2b_stall_cnt got %0d expected 7", stallCnt);
        end
    endtask

    task automatic test_saturation();
        vec_t hz;
        vec_t idle;
        hz   = '{5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, LU};
        idle = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, RUNV};
        doReset();
        for (int i = 0; i < 20; i++) begin
            step(hz);
            expV = sbq.pop_front();
            checks++;
            if (obsVec() !== expV) begin
                errors++;
                $display("[TB] FAIL sat_hold[%0d] got %b expected %b", i, obsVec(), expV);
            end
        end
        step(idle);
        expV = sbq.pop_front();
        checks++;
        if (obsVec() !== expV) begin
            errors++;
            $display("[TB] FAIL sat_idle got %b expected %b", obsVec(), expV);
        end
        checks++;
        if (sStall !== 4'd15) begin
            errors++;
            $display("[TB] FAIL sat_small_cnt got %0d expected 15", sStall);
        end
        checks++;
        if (stallCnt !== 16'd20) begin
            errors++;
            $display("[TB] FAIL sat_wide_cnt got %0d expected 20", stallCnt);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before summary, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_mult();
        test_branch_hazard();
        test_reset_md_wait();
        test_back_to_back();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
